hdmi_fetch_ctrl: RTL
====================

# hdmi_fetch_ctrl

Framebuffer fetch scheduler for the HDMI path. It runs in the system clock domain. Each frame it walks the active image in the framebuffer with pipelined Wishbone reads and pushes the returned 32-bit words into the write side of the pixel async FIFO. It throttles against FIFO fill and bounds the number of in-flight reads. It sits between `hdmi_core_ctrl` (enable, base address) and the `afifo` write port inside `hdmi_core`.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `FIFO_ASIZE`, 11: log2 of the pixel FIFO depth, in words.
- `MAX_OUTSTANDING`, 4: maximum accepted but unacknowledged reads.
- `HEADROOM`, 8: FIFO words kept free beyond the outstanding reads.
- Derived: `LINE_WORDS` = H_ACTIVE*3/4 (24 bpp packed). `FRAME_WORDS` = LINE_WORDS*V_ACTIVE (230400 at default).
- Elaboration check: H_ACTIVE*3 must be divisible by 4.

Ports (clock and reset first):
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  `hdmi_config.is_enabled`.
- `base_addr_i`  in  32  framebuffer byte base address, word aligned; bits [1:0] ignored; sampled at frame start.
- `frame_start_i`  in  1  one-cycle pulse, already synchronized into the `clk_i` domain, at the start of vertical blanking.
- `fifo_wfill_i`  in  FIFO_ASIZE+1  write-side fill count; conservative, never under-reports.
- `fetch_if`  master  wishbone_if  pipelined read master; `we`=0, `sel`=4'hF.
- `fifo_wr_o`  out  1  FIFO write strobe.
- `fifo_wdata_o`  out  32  FIFO write data.
- `busy_o`  out  1  high in any state other than IDLE.
- `frame_done_o`  out  1  one-cycle pulse when a full frame has been written.
- `err_o`  out  1  sticky Wishbone error; cleared only by reset.
- `late_o`  out  1  sticky; `frame_start_i` arrived while `busy_o` was high; cleared only by reset.

## Operation
- States: IDLE, FETCH, DRAIN, ABORT.
- **IDLE → FETCH** when `enable_i & frame_start_i`.
  - Latch the base address.
  - Clear the issue index `iss` and the ack counter `ackd`.
  - Raise `cyc`.
- **FETCH issue rule:** `stb` = `iss<FRAME_WORDS & out<MAX_OUTSTANDING & fifo_wfill_i+out+HEADROOM < 2^FIFO_ASIZE`.
  - `addr` = base + 4*`iss`.
  - `iss` increments on `stb & !stall`.
- **Outstanding counter `out`:**
  - +1 on an accepted request.
  - -1 on `ack` or `err`.
  - Both in the same cycle: unchanged.
- **Ack handling:** each `ack` writes `dat_i` to the FIFO and increments `ackd`.
- **FETCH → DRAIN** when `iss==FRAME_WORDS` after acceptance, or when `enable_i` falls. `stb` drops immediately.
- **DRAIN:** `cyc` held high until `out==0`, then drop `cyc`.
  - If `ackd==FRAME_WORDS`, pulse `frame_done_o`.
  - Go to IDLE.
- **`err` in FETCH or DRAIN:** set `err_o`, go to ABORT.
  - Further acks are discarded (no FIFO write).
  - When `out==0`: drop `cyc`, go to IDLE, no `frame_done_o`.
- **`frame_start_i` while not IDLE:** ignored, sets `late_o`.
- **Disabled:** `enable_i` low in IDLE keeps the block in IDLE.
- **Counter widths:** `iss` and `ackd` are $clog2(FRAME_WORDS+1) bits and never wrap. Address arithmetic is 32-bit modulo.

## Timing
- Reset values:
  - State IDLE.
  - `cyc`, `stb`, `fifo_wr_o`, `busy_o`, `frame_done_o`, `err_o`, `late_o` all 0.
  - `addr`, `fifo_wdata_o`, counters all 0.
- First `stb` appears 1 cycle after the accepted `frame_start_i` (registered state).
- `stb`, `addr`, `cyc` are registered outputs.
- `stb`/`addr` hold while `stall` is high.
- FIFO write latency: `fifo_wr_o`/`fifo_wdata_o` are registered, 1 cycle after `ack`.
- The FIFO full condition is never reached given a conservative `fifo_wfill_i`. If `fifo_wfill_i` saturates, `stb` stays low (no loss).
- `frame_done_o` is asserted in the cycle `cyc` falls. It appears 1 cycle after the final FIFO write at the earliest.
- Back-to-back frames: a `frame_start_i` in the same cycle as the return to IDLE is treated as late.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately (asynchronous).
  - In-flight acks after release are ignored, because `cyc` is low.

## Structure
- Shared constants go into `hdmi_pkg`:
  - `fetch_state_e` enum.
  - Default timing constants H_ACTIVE/V_ACTIVE.
  - `BYTES_PER_PIXEL`=3.
- Single module, no sub-modules.
- Counters and the FSM live in one always_ff block with async `rst_i`.
- `hdmi_core` instantiates the block, inverting `rstn_i` to drive `rst_i`.

## Test plan
All scenarios use H_ACTIVE=8, V_ACTIVE=2 (12 words), MAX_OUTSTANDING=4.
- **Basic frame:** base 0x8000_0000, zero-wait slave.
  - 12 reads, addresses 0x8000_0000..0x8000_002C.
  - 12 FIFO writes in order.
  - `frame_done_o` pulses once; `busy_o` drops.
- **Stall/latency:** slave stalls every other cycle, ack latency 3.
  - `out` never exceeds 4.
  - Data order preserved; `frame_done_o` pulses once.
- **Backpressure:** hold `fifo_wfill_i`=2040 (ASIZE 11, HEADROOM 8) → `stb` stays 0. Drop it to 0 → fetch resumes and completes.
- **Error:** `err` on the 5th request.
  - `err_o`=1.
  - The remaining outstanding acks produce no FIFO writes.
  - No `frame_done_o`; returns to IDLE.
- **Disable/late:** deassert `enable_i` after 6 requests → drain, return to IDLE, no `frame_done_o`. A `frame_start_i` pulse during the drain sets `late_o`.
- **Async reset mid-FETCH:** all outputs go to 0 immediately. A new `frame_start_i` after release restarts from the base address.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared HDMI-path types and default timing constants.
package hdmi_pkg;

  localparam int unsigned H_ACTIVE_DEF    = 640;
  localparam int unsigned V_ACTIVE_DEF    = 480;
  localparam int unsigned BYTES_PER_PIXEL = 3;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_FETCH,
    FS_DRAIN,
    FS_ABORT
  } fetch_state_e;

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone bus bundle; addr/data are 32-bit, byte-addressed.
interface wishbone_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, addr, dat_w,
    input  dat_r, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, sel, addr, dat_w,
    output dat_r, ack, err, stall
  );

endinterface

// File: rtl/hdmi_fetch_ctrl.sv
// Per-frame framebuffer reader: issues pipelined Wishbone reads, throttled by
// FIFO fill and an in-flight limit, and writes returned words to the pixel FIFO.
module hdmi_fetch_ctrl
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE        = V_ACTIVE_DEF,
  parameter int unsigned FIFO_ASIZE      = 11,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned HEADROOM        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [31:0]           base_addr_i,
  input  logic                  frame_start_i,
  input  logic [FIFO_ASIZE:0]   fifo_wfill_i,
  wishbone_if.master            fetch_if,
  output logic                  fifo_wr_o,
  output logic [31:0]           fifo_wdata_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  err_o,
  output logic                  late_o
);

  localparam int unsigned LINE_WORDS  = H_ACTIVE * BYTES_PER_PIXEL / 4;
  localparam int unsigned FRAME_WORDS = LINE_WORDS * V_ACTIVE;
  localparam int unsigned CW          = $clog2(FRAME_WORDS + 1);
  localparam int unsigned OW          = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DEPTH       = 1 << FIFO_ASIZE;

  if ((H_ACTIVE * BYTES_PER_PIXEL) % 4 != 0) begin : g_bad_geometry
    $error("hdmi_fetch_ctrl: H_ACTIVE*3 must be a multiple of 4");
  end

  fetch_state_e   state_q;
  logic [CW-1:0]  iss_q;
  logic [CW-1:0]  ackd_q;
  logic [OW-1:0]  out_q;
  logic [31:0]    base_q;
  logic           cyc_q;
  logic           stb_q;
  logic [31:0]    addr_q;

  logic           acc;
  logic           rsp;
  logic           wb_err;
  logic           ack_ok;
  logic [OW-1:0]  out_n;
  logic [CW-1:0]  iss_n;
  logic           start_ok;
  logic           issue_ok;

  always_comb begin
    acc      = stb_q & ~fetch_if.stall;
    // Responses only count while a cycle is open and something is in flight,
    // so acks arriving after an asynchronous reset cannot corrupt the counter.
    rsp      = cyc_q & (fetch_if.ack | fetch_if.err) & (out_q != '0);
    wb_err   = cyc_q & fetch_if.err;
    ack_ok   = cyc_q & fetch_if.ack & ~fetch_if.err &
               ((state_q == FS_FETCH) || (state_q == FS_DRAIN));
    out_n    = out_q;
    if (acc && !rsp) begin
      out_n = out_q + OW'(1);
    end else if (!acc && rsp) begin
      out_n = out_q - OW'(1);
    end
    iss_n    = iss_q + CW'(acc);
    start_ok = (32'(fifo_wfill_i) + HEADROOM) < DEPTH;
    issue_ok = (iss_n < CW'(FRAME_WORDS)) &&
               (out_n < OW'(MAX_OUTSTANDING)) &&
               ((32'(fifo_wfill_i) + 32'(out_n) + HEADROOM) < DEPTH);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= FS_IDLE;
      iss_q        <= '0;
      ackd_q       <= '0;
      out_q        <= '0;
      base_q       <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      addr_q       <= '0;
      fifo_wr_o    <= 1'b0;
      fifo_wdata_o <= '0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
      late_o       <= 1'b0;
    end else begin
      fifo_wr_o    <= 1'b0;
      frame_done_o <= 1'b0;
      out_q        <= out_n;

      if (frame_start_i && (state_q != FS_IDLE)) begin
        late_o <= 1'b1;
      end

      if (ack_ok) begin
        fifo_wr_o    <= 1'b1;
        fifo_wdata_o <= fetch_if.dat_r;
        ackd_q       <= ackd_q + CW'(1);
      end

      case (state_q)
        FS_IDLE: begin
          if (enable_i && frame_start_i) begin
            base_q  <= base_addr_i & ~32'h3;
            addr_q  <= base_addr_i & ~32'h3;
            iss_q   <= '0;
            ackd_q  <= '0;
            out_q   <= '0;
            cyc_q   <= 1'b1;
            stb_q   <= start_ok;
            state_q <= FS_FETCH;
          end
        end
        FS_FETCH: begin
          iss_q <= iss_n;
          if (wb_err) begin
            err_o   <= 1'b1;
            stb_q   <= 1'b0;
            state_q <= FS_ABORT;
          end else if (!enable_i || (iss_n == CW'(FRAME_WORDS))) begin
            stb_q   <= 1'b0;
            state_q <= FS_DRAIN;
          end else if (!(stb_q && fetch_if.stall)) begin
            stb_q  <= issue_ok;
            addr_q <= base_q + (32'(iss_n) << 2);
          end
        end
        FS_DRAIN: begin
          if (wb_err) begin
            err_o   <= 1'b1;
            state_q <= FS_ABORT;
          end else if (out_q == '0) begin
            cyc_q        <= 1'b0;
            frame_done_o <= (ackd_q == CW'(FRAME_WORDS));
            state_q      <= FS_IDLE;
          end
        end
        FS_ABORT: begin
          if (out_q == '0) begin
            cyc_q   <= 1'b0;
            state_q <= FS_IDLE;
          end
        end
        default: state_q <= FS_IDLE;
      endcase
    end
  end

  assign busy_o         = (state_q != FS_IDLE);
  assign fetch_if.cyc   = cyc_q;
  assign fetch_if.stb   = stb_q;
  assign fetch_if.addr  = addr_q;
  assign fetch_if.we    = 1'b0;
  assign fetch_if.sel   = 4'hF;
  assign fetch_if.dat_w = '0;

endmodule
